// File: rtl/uart_cfg.sv
// Parametrised full-duplex UART with runtime parity/stop selection and error flags.
// Define UART_CFG_RX_FIFO_EN to queue received words in an RX_FIFO_DEPTH-entry FIFO.
module uart_cfg #(
  parameter int WORD_LENGTH   = 8,
  parameter int CLKS_PER_BIT  = 16,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   SerialDataIn,
  input  logic                   Clear_RX_Flag,
  input  logic [WORD_LENGTH-1:0] DATATX,
  input  logic                   Transmit,
  input  logic [1:0]             ParityMode,
  input  logic                   TwoStopBits,
  output logic [WORD_LENGTH-1:0] DATARX,
  output logic                   RX_FLAG,
  output logic                   ParityError,
  output logic                   FramingError,
  output logic                   Overrun,
  output logic                   SerialDataOut,
  output logic                   TX_BUSY
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(WORD_LENGTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_LENGTH - 1);

  if (CLKS_PER_BIT < 4 || RX_FIFO_DEPTH < 2) begin : g_bad_param
    $error("uart_cfg: CLKS_PER_BIT must be >= 4 and RX_FIFO_DEPTH >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic par_en(input logic [1:0] m);
    return m[0] ^ m[1];
  endfunction

  function automatic logic par_odd(input logic [1:0] m);
    return m[1] & ~m[0];
  endfunction

  // RX input synchroniser and falling-edge detect
  logic rx_s1, rx_s2, rx_prev, rx_fall;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= SerialDataIn;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end
  assign rx_fall = rx_prev & ~rx_s2;

  // RX frame FSM
  state_t                 rx_state, rx_next;
  logic [BAUD_W-1:0]      rx_baud;
  logic [BIT_W-1:0]       rx_bit;
  logic                   rx_stop_cnt, rx_two, rx_tick, rx_last_stop;
  logic [1:0]             rx_mode;
  logic [WORD_LENGTH-1:0] rx_shreg;
  logic                   rx_par_bit, rx_ferr_acc, rx_done, rx_perr_res, rx_ferr_res;

  assign rx_tick      = (rx_state == S_START) ? (rx_baud == HALF_LAST) : (rx_baud == BAUD_LAST);
  assign rx_last_stop = (rx_state == S_STOP) && rx_tick && (rx_stop_cnt || !rx_two);

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:   if (rx_fall) rx_next = S_START;
      S_START:  if (rx_tick) rx_next = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:   if (rx_tick && rx_bit == BIT_LAST) rx_next = par_en(rx_mode) ? S_PARITY : S_STOP;
      S_PARITY: if (rx_tick) rx_next = S_STOP;
      S_STOP:   if (rx_last_stop) rx_next = S_IDLE;
      default:  rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state    <= S_IDLE;
      rx_baud     <= '0;
      rx_bit      <= '0;
      rx_stop_cnt <= 1'b0;
      rx_mode     <= 2'b00;
      rx_two      <= 1'b0;
      rx_ferr_acc <= 1'b0;
      rx_done     <= 1'b0;
      rx_perr_res <= 1'b0;
      rx_ferr_res <= 1'b0;
    end else begin
      rx_state <= rx_next;
      rx_done  <= rx_last_stop;
      if (rx_state == S_IDLE || rx_tick) rx_baud <= '0;
      else                               rx_baud <= rx_baud + 1'b1;
      if (rx_state == S_IDLE) begin
        rx_bit      <= '0;
        rx_stop_cnt <= 1'b0;
        rx_ferr_acc <= 1'b0;
        if (rx_fall) begin
          rx_mode <= ParityMode;
          rx_two  <= TwoStopBits;
        end
      end
      if (rx_state == S_DATA && rx_tick) rx_bit <= (rx_bit == BIT_LAST) ? '0 : rx_bit + 1'b1;
      if (rx_state == S_STOP && rx_tick) begin
        rx_stop_cnt <= 1'b1;
        if (!rx_s2) rx_ferr_acc <= 1'b1;
      end
      if (rx_last_stop) begin
        rx_ferr_res <= rx_ferr_acc | ~rx_s2;
        rx_perr_res <= par_en(rx_mode) & (rx_par_bit ^ (^rx_shreg) ^ par_odd(rx_mode));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == S_DATA && rx_tick)   rx_shreg   <= {rx_s2, rx_shreg[WORD_LENGTH-1:1]};
    if (rx_state == S_PARITY && rx_tick) rx_par_bit <= rx_s2;
  end

`ifdef UART_CFG_RX_FIFO_EN
  localparam int PTR_W = $clog2(RX_FIFO_DEPTH);
  logic [WORD_LENGTH+1:0] fifo_mem [RX_FIFO_DEPTH];
  logic [PTR_W:0]         wr_ptr, rd_ptr;
  logic                   fifo_empty, fifo_full, fifo_push, fifo_pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fifo_pop   = Clear_RX_Flag && !fifo_empty;
  assign fifo_push  = rx_done && (!fifo_full || fifo_pop);

  // A completing frame only overruns when no slot is freed in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      Overrun <= 1'b0;
      for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (fifo_push) begin
        fifo_mem[wr_ptr[PTR_W-1:0]] <= {rx_perr_res, rx_ferr_res, rx_shreg};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      if (rx_done && !fifo_push) Overrun <= 1'b1;
      else if (Clear_RX_Flag)    Overrun <= 1'b0;
    end
  end

  logic [WORD_LENGTH+1:0] fifo_head;
  assign fifo_head    = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign DATARX       = fifo_head[WORD_LENGTH-1:0];
  assign FramingError = fifo_head[WORD_LENGTH] & ~fifo_empty;
  assign ParityError  = fifo_head[WORD_LENGTH+1] & ~fifo_empty;
  assign RX_FLAG      = ~fifo_empty;
`else
  // Completion beats a simultaneous clear, and then does not count as overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      DATARX       <= '0;
      RX_FLAG      <= 1'b0;
      ParityError  <= 1'b0;
      FramingError <= 1'b0;
      Overrun      <= 1'b0;
    end else if (rx_done) begin
      DATARX       <= rx_shreg;
      RX_FLAG      <= 1'b1;
      ParityError  <= rx_perr_res;
      FramingError <= rx_ferr_res;
      Overrun      <= Clear_RX_Flag ? 1'b0 : (Overrun | RX_FLAG);
    end else if (Clear_RX_Flag) begin
      RX_FLAG      <= 1'b0;
      ParityError  <= 1'b0;
      FramingError <= 1'b0;
      Overrun      <= 1'b0;
    end
  end
`endif

  // TX frame FSM
  state_t                 tx_state, tx_next;
  logic [BAUD_W-1:0]      tx_baud;
  logic [BIT_W-1:0]       tx_bit;
  logic                   tx_stop_cnt, tx_two, tx_tick, tx_par;
  logic [1:0]             tx_mode;
  logic [WORD_LENGTH-1:0] tx_shreg;

  assign tx_tick = (tx_baud == BAUD_LAST);

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:   if (Transmit) tx_next = S_START;
      S_START:  if (tx_tick) tx_next = S_DATA;
      S_DATA:   if (tx_tick && tx_bit == BIT_LAST) tx_next = par_en(tx_mode) ? S_PARITY : S_STOP;
      S_PARITY: if (tx_tick) tx_next = S_STOP;
      S_STOP:   if (tx_tick && (tx_stop_cnt || !tx_two)) tx_next = S_IDLE;
      default:  tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state    <= S_IDLE;
      tx_baud     <= '0;
      tx_bit      <= '0;
      tx_stop_cnt <= 1'b0;
      tx_mode     <= 2'b00;
      tx_two      <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == S_IDLE || tx_tick) tx_baud <= '0;
      else                               tx_baud <= tx_baud + 1'b1;
      if (tx_state == S_IDLE) begin
        tx_bit      <= '0;
        tx_stop_cnt <= 1'b0;
        if (Transmit) begin
          tx_mode <= ParityMode;
          tx_two  <= TwoStopBits;
        end
      end
      if (tx_state == S_DATA && tx_tick) tx_bit <= (tx_bit == BIT_LAST) ? '0 : tx_bit + 1'b1;
      if (tx_state == S_STOP && tx_tick) tx_stop_cnt <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_state == S_IDLE && Transmit) begin
      tx_shreg <= DATATX;
      tx_par   <= (^DATATX) ^ par_odd(ParityMode);
    end else if (tx_state == S_DATA && tx_tick) begin
      tx_shreg <= tx_shreg >> 1;
    end
  end

  always_comb begin
    SerialDataOut = 1'b1;
    case (tx_state)
      S_START:  SerialDataOut = 1'b0;
      S_DATA:   SerialDataOut = tx_shreg[0];
      S_PARITY: SerialDataOut = tx_par;
      default:  SerialDataOut = 1'b1;
    endcase
  end

  assign TX_BUSY = (tx_state != S_IDLE);

endmodule

// File: tb/tb_uart_cfg.sv
// Directed self-checking bench for uart_cfg (default build, 8 data bits, 16 clks/bit).
module tb_uart_cfg;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       SerialDataIn;
  logic       Clear_RX_Flag;
  logic [7:0] DATATX;
  logic       Transmit;
  logic [1:0] ParityMode;
  logic       TwoStopBits;
  logic [7:0] DATARX;
  logic       RX_FLAG, ParityError, FramingError, Overrun, SerialDataOut, TX_BUSY;

  int n_chk  = 0;
  int n_pass = 0;

  uart_cfg #(.WORD_LENGTH(8), .CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .SerialDataIn(SerialDataIn), .Clear_RX_Flag(Clear_RX_Flag),
    .DATATX(DATATX), .Transmit(Transmit), .ParityMode(ParityMode), .TwoStopBits(TwoStopBits),
    .DATARX(DATARX), .RX_FLAG(RX_FLAG), .ParityError(ParityError), .FramingError(FramingError),
    .Overrun(Overrun), .SerialDataOut(SerialDataOut), .TX_BUSY(TX_BUSY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic drive_bit(input logic b);
    SerialDataIn = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic [1:0] mode, input logic two,
                          input logic pbit, input logic s1, input logic s2);
    ParityMode  = mode;
    TwoStopBits = two;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (mode == 2'b01 || mode == 2'b10) drive_bit(pbit);
    drive_bit(s1);
    if (two) drive_bit(s2);
    SerialDataIn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_flag();
    Clear_RX_Flag = 1'b1;
    @(negedge clk);
    Clear_RX_Flag = 1'b0;
    @(negedge clk);
  endtask

  // Mid-frame a second Transmit, new data and another parity mode are applied; all must be ignored
  task automatic tx_frame(input logic [7:0] d, input logic [1:0] mode, input logic two,
                          input logic exp_par, input int exp_len);
    int   cyc, busy, k;
    logic e;
    DATATX = d; ParityMode = mode; TwoStopBits = two; Transmit = 1'b1;
    @(negedge clk);
    Transmit = 1'b0;
    cyc = 0; busy = 0;
    while (TX_BUSY && cyc < 400) begin
      if (cyc % CPB == CPB / 2) begin
        k = cyc / CPB;
        if (k == 0)      e = 1'b0;
        else if (k <= 8) e = d[k-1];
        else if (k == 9 && (mode == 2'b01 || mode == 2'b10)) e = exp_par;
        else             e = 1'b1;
        check($sformatf("tx_bit%0d", k), {31'b0, SerialDataOut}, {31'b0, e});
      end
      if (cyc == 40) begin
        Transmit = 1'b1; DATATX = ~d; ParityMode = ~mode; TwoStopBits = ~two;
      end else begin
        Transmit = 1'b0; DATATX = d; ParityMode = mode; TwoStopBits = two;
      end
      busy++; cyc++;
      @(negedge clk);
    end
    check("tx_busy_len", busy, exp_len);
    check("tx_idle_line", {31'b0, SerialDataOut}, 32'd1);
  endtask

  initial begin
    reset = 1'b0; SerialDataIn = 1'b1; Clear_RX_Flag = 1'b0; DATATX = 8'h00;
    Transmit = 1'b0; ParityMode = 2'b00; TwoStopBits = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", {31'b0, SerialDataOut}, 32'd1);
    check("rst_busy", {31'b0, TX_BUSY}, 32'd0);
    check("rst_flag", {31'b0, RX_FLAG}, 32'd0);
    check("rst_datarx", {24'b0, DATARX}, 32'h00);
    check("rst_errs", {29'b0, ParityError, FramingError, Overrun}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // TX: even parity 1 stop, then odd parity 2 stops
    tx_frame(8'h32, 2'b01, 1'b0, 1'b1, 176);
    tx_frame(8'h0F, 2'b10, 1'b1, 1'b1, 192);

    // RX parity
    rx_frame(8'h96, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
    check("rx96_flag", {31'b0, RX_FLAG}, 32'd1);
    check("rx96_data", {24'b0, DATARX}, 32'h96);
    check("rx96_perr", {31'b0, ParityError}, 32'd0);
    check("rx96_ferr", {31'b0, FramingError}, 32'd0);
    clear_flag();
    check("clr_flag", {31'b0, RX_FLAG}, 32'd0);
    rx_frame(8'h96, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
    check("rx96b_data", {24'b0, DATARX}, 32'h96);
    check("rx96b_perr", {31'b0, ParityError}, 32'd1);
    clear_flag();
    check("clr_perr", {31'b0, ParityError}, 32'd0);
    rx_frame(8'h96, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
    check("rx96_odd_perr", {31'b0, ParityError}, 32'd0);
    check("rx96_odd_flag", {31'b0, RX_FLAG}, 32'd1);
    clear_flag();

    // RX framing error on second stop bit
    rx_frame(8'h55, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    check("rx55_data", {24'b0, DATARX}, 32'h55);
    check("rx55_ferr", {31'b0, FramingError}, 32'd1);
    check("rx55_perr", {31'b0, ParityError}, 32'd0);
    clear_flag();
    check("clr_ferr", {31'b0, FramingError}, 32'd0);

    // Short low glitch
    SerialDataIn = 1'b0;
    repeat (4) @(negedge clk);
    SerialDataIn = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_flag", {31'b0, RX_FLAG}, 32'd0);
    check("glitch_errs", {29'b0, ParityError, FramingError, Overrun}, 32'd0);
    check("glitch_data", {24'b0, DATARX}, 32'h55);

    // Overrun
    rx_frame(8'hA1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ovr_first", {31'b0, Overrun}, 32'd0);
    check("ovr_first_data", {24'b0, DATARX}, 32'hA1);
    rx_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ovr_set", {31'b0, Overrun}, 32'd1);
    check("ovr_data", {24'b0, DATARX}, 32'h3C);
    check("ovr_flag", {31'b0, RX_FLAG}, 32'd1);
    clear_flag();
    check("ovr_clr_flag", {31'b0, RX_FLAG}, 32'd0);
    check("ovr_clr", {31'b0, Overrun}, 32'd0);
    check("ovr_hold_data", {24'b0, DATARX}, 32'h3C);

    // Reset in the middle of a TX and an RX frame
    rx_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("pre_rst_flag", {31'b0, RX_FLAG}, 32'd1);
    DATATX = 8'h5A; ParityMode = 2'b00; TwoStopBits = 1'b0; Transmit = 1'b1; SerialDataIn = 1'b0;
    @(negedge clk);
    Transmit = 1'b0;
    repeat (40) @(negedge clk);
    check("pre_rst_busy", {31'b0, TX_BUSY}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_txd", {31'b0, SerialDataOut}, 32'd1);
    check("mid_rst_busy", {31'b0, TX_BUSY}, 32'd0);
    check("mid_rst_flag", {31'b0, RX_FLAG}, 32'd0);
    check("mid_rst_data", {24'b0, DATARX}, 32'h00);
    repeat (3) @(negedge clk);
    SerialDataIn = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_flag", {31'b0, RX_FLAG}, 32'd0);
    rx_frame(8'hC3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("post_rst_data", {24'b0, DATARX}, 32'hC3);
    check("post_rst_rxflag", {31'b0, RX_FLAG}, 32'd1);
    check("post_rst_ferr", {31'b0, FramingError}, 32'd0);
    tx_frame(8'hA5, 2'b00, 1'b0, 1'b0, 160);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_cfg.md
Name: uart_cfg

Overview:
Parametrised full-duplex UART, the successor to the fixed-format UART core. Word length and oversampling ratio are set by parameters. Parity mode (none/even/odd) and stop-bit count are selected at runtime. It adds framing-error, overrun and glitch-rejection detection, and a TX busy indication. It sits between the register/host logic and the board serial pins.

Parameters:
WORD_LENGTH, 8, data bits per frame (5..9 supported).
CLKS_PER_BIT, 16, clk cycles per bit period (even, >=4).
RX_FIFO_DEPTH, 4, RX FIFO entries (power of 2). Used only when UART_CFG_RX_FIFO_EN is defined.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
SerialDataIn  in  1  RX line, idle high, asynchronous to clk.
Clear_RX_Flag  in  1  pulse; acknowledges received data and errors.
DATATX  in  WORD_LENGTH  data to transmit.
Transmit  in  1  pulse; start TX when idle.
ParityMode  in  2  00 none, 01 even, 10 odd, 11 none.
TwoStopBits  in  1  0 = 1 stop bit, 1 = 2 stop bits.
DATARX  out  WORD_LENGTH  last received word.
RX_FLAG  out  1  received word available.
ParityError  out  1  parity mismatch on the word in DATARX.
FramingError  out  1  a stop bit was sampled low.
Overrun  out  1  frame completed while RX_FLAG was already set.
SerialDataOut  out  1  TX line.
TX_BUSY  out  1  frame in progress.

Behaviour:
- Reset (async, reset=0): all FSMs go to IDLE. SerialDataOut=1. DATARX=0. RX_FLAG, ParityError, FramingError, Overrun and TX_BUSY are all 0. Reset mid-frame aborts the frame immediately; no partial word is delivered.
- ParityMode and TwoStopBits are latched at frame start and held for the whole frame.
- Bit order is LSB first. Even parity bit = XOR(data); odd parity bit = ~XOR(data).
- RX synchroniser: 2-flop synchroniser on SerialDataIn. All RX logic uses the synchronised signal.
- RX FSM, states IDLE -> START -> DATA -> PARITY (skipped if no parity) -> STOP -> IDLE.
  - IDLE: waits for a synchronised falling edge.
  - START: counts CLKS_PER_BIT/2 and samples. If the line is high, the event is a glitch: return to IDLE, no flags change.
  - DATA, PARITY, STOP: each bit is sampled every CLKS_PER_BIT cycles after the start-bit mid-sample.
  - STOP: every stop bit is sampled. Any low stop bit sets the framing-error result for the frame.
- RX completion (cycle after the last stop-bit sample): DATARX takes the word, RX_FLAG=1, and ParityError and FramingError take this frame's results.
  - ParityError is 0 when parity is none.
  - If RX_FLAG was already 1, Overrun=1 and DATARX is overwritten.
  - The receiver returns to IDLE right after the last stop-bit mid-sample, so back-to-back frames are accepted.
- Clear_RX_Flag: clears RX_FLAG, Overrun, ParityError and FramingError on the next edge. DATARX holds its value. If Clear_RX_Flag and a completion occur in the same cycle, the completion wins: flags are set and Overrun is not raised.
- TX FSM, states IDLE -> START -> DATA -> PARITY (optional) -> STOP (1 or 2) -> IDLE.
  - Transmit=1 in IDLE latches DATATX.
  - TX_BUSY=1 and SerialDataOut=0 from the next edge.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - TX_BUSY drops in the cycle after the last stop bit ends.
  - Transmit while TX_BUSY=1 is ignored; changing DATATX during a frame has no effect.
  - Frame length is (1 + WORD_LENGTH + P + S) * CLKS_PER_BIT cycles, where P = 1 if parity is enabled (else 0) and S = stop-bit count.
- Counters: the bit counter is ceil(log2(WORD_LENGTH+1)) bits wide; the baud counter is ceil(log2(CLKS_PER_BIT)) bits wide. Both wrap to 0 at each bit boundary.

Optional Feature:
UART_CFG_RX_FIFO_EN.
- Defined:
  - Received words and their error bits go into an RX_FIFO_DEPTH-deep FIFO.
  - DATARX, ParityError and FramingError show the head entry; RX_FLAG = not empty.
  - Clear_RX_Flag pops one entry; a pop when empty is ignored.
  - Overrun=1 only when a frame completes while the FIFO is full. That frame is dropped and the FIFO contents are kept.
  - A push and a pop in the same cycle are both performed.
  - Overrun clears on the next Clear_RX_Flag.
- Undefined: single holding register, with behaviour as described above.

Test Plan:
1. CLKS_PER_BIT=16, ParityMode=01, TwoStopBits=0, DATATX=0x32, Transmit pulse -> SerialDataOut = 0, then 0,1,0,0,1,1,0,0, parity 1, stop 1; 16 cycles per bit; TX_BUSY high for 176 cycles.
2. RX 0x96 (LSB first 0,1,1,0,1,0,0,1), even parity bit 0, stop 1 -> RX_FLAG=1, DATARX=0x96, ParityError=0. Repeat with parity bit 1 -> ParityError=1.
3. RX 0x55, ParityMode=00, TwoStopBits=1, second stop bit low -> DATARX=0x55, FramingError=1.
4. SerialDataIn low for 4 cycles, then high -> no RX_FLAG, all flags unchanged.
5. Two frames 0xA1 then 0x3C with no Clear_RX_Flag -> Overrun=1, DATARX=0x3C (FIFO build: Overrun only after DEPTH+1 frames). Clear_RX_Flag -> RX_FLAG=0, Overrun=0.
6. reset=0 during the DATA state of a TX and an RX frame -> SerialDataOut=1, TX_BUSY=0, RX_FLAG=0 immediately. The next frame after reset=1 is received correctly.
